dmem_arbiter: RTL and testbench

- Shares the single-port data_memory between two requesters: port 0 is the pipeline MEM stage and port 1 is the loader/debug port.
- Issues one registered memory command at a time.
- Arbitrates round-robin when both ports request in the same cycle.
- Returns read data to the requester with a fixed, parameterised latency.
- Sits between the EX/MEM pipeline register and data_memory. Port 0's gnt doubles as the pipeline stall release.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   - state_t   : arbiter FSM encoding (IDLE/WRITE/READ/RESP)
//   - PORT0/1   : owner encoding of a latched command
//   - ADDR_W_DEF/DATA_W_DEF : default widths shared with data_memory
//   - gnt_owner : maps a one-hot grant vector to the owner encoding
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Grant vector is one-hot or zero; bit 1 set means port 1 owns the command.
  function automatic logic gnt_owner(input logic [1:0] gnt);
    return gnt[1] ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
// Ports:
//   i_en      - arbitration allowed this cycle (FSM in IDLE or RESP)
//   i_req     - request vector {port1, port0}
//   i_rr_last - owner of the most recent grant
//   o_gnt     - one-hot grant (or zero)
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  output logic [1:0] o_gnt
);

  // Single requester wins outright; on a tie the port that did not win last goes.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (i_rr_last == PORT1) ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end else begin
      o_gnt = 2'b00;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data_memory between the pipeline MEM
// stage (port 0) and the loader/debug port (port 1). One command in flight;
// reads return after a fixed RD_LAT-cycle MemRead window plus one RESP cycle.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   mN_req/we/addr/wdata       - requester N command (held until mN_gnt)
//   mN_gnt                     - command accepted this cycle (combinational)
//   mN_rvalid, mN_rdata        - one-cycle read response pulse, held read data
//   MemRead, MemWrite, mem_addr, mem_wdata, mem_rdata - data_memory interface
// Optional (macro DMEM_ARB_PERF_EN):
//   conflict_cnt - saturating count of arbitration cycles with both requests
//   m0_wait_cnt  - saturating count of cycles port 0 requests without grant
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = 1            // legal range 1..4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       m0_wait_cnt
`endif
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t            r_state;
  logic              r_rr_last;
  logic              r_owner;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_arb_en;
  logic [1:0]        w_gnt;
  logic              w_win;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  assign w_arb_en = (r_state == IDLE) || (r_state == RESP);

  rr_arb2 u_rr_arb2 (
    .i_en      (w_arb_en),
    .i_req     ({m1_req, m0_req}),
    .i_rr_last (r_rr_last),
    .o_gnt     (w_gnt)
  );

  assign w_win  = gnt_owner(w_gnt);
  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  // Select the winning requester's command fields for latching.
  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = {ADDR_W{1'b0}};
    w_win_wdata = {DATA_W{1'b0}};
    if (w_win == PORT1) begin
      w_win_we    = m1_we;
      w_win_addr  = m1_addr;
      w_win_wdata = m1_wdata;
    end else begin
      w_win_we    = m0_we;
      w_win_addr  = m0_addr;
      w_win_wdata = m0_wdata;
    end
  end

  // Arbiter FSM: command latch, read-latency countdown and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_last   <= PORT1;
      r_owner     <= PORT0;
      r_cmd_addr  <= {ADDR_W{1'b0}};
      r_cmd_wdata <= {DATA_W{1'b0}};
      r_cnt       <= 2'd0;
      r_m0_rdata  <= {DATA_W{1'b0}};
      r_m1_rdata  <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        // RESP arbitrates exactly like IDLE so reads can run back-to-back.
        IDLE, RESP: begin
          if (w_gnt != 2'b00) begin
            r_owner     <= w_win;
            r_rr_last   <= w_win;
            r_cmd_addr  <= w_win_addr;
            r_cmd_wdata <= w_win_wdata;
            r_cnt       <= LAT_M1;
            r_state     <= w_win_we ? WRITE : READ;
          end else begin
            r_state     <= IDLE;
          end
        end
        WRITE: begin
          r_state <= IDLE;
        end
        READ: begin
          if (r_cnt == 2'd0) begin
            if (r_owner == PORT1) begin
              r_m1_rdata <= mem_rdata;
            end else begin
              r_m0_rdata <= mem_rdata;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes decode straight from the state register, so an async
  // reset drops them in the same instant it returns the FSM to IDLE.
  assign MemWrite  = (r_state == WRITE);
  assign MemRead   = (r_state == READ);
  assign mem_addr  = (MemRead || MemWrite) ? r_cmd_addr : {ADDR_W{1'b0}};
  assign mem_wdata = MemWrite ? r_cmd_wdata : {DATA_W{1'b0}};

  assign m0_rvalid = (r_state == RESP) && (r_owner == PORT0);
  assign m1_rvalid = (r_state == RESP) && (r_owner == PORT1);
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] r_conflict_cnt;
  logic [15:0] r_m0_wait_cnt;

  // Saturating performance counters for arbitration conflicts and port 0 stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 16'd0;
      r_m0_wait_cnt  <= 16'd0;
    end else begin
      if (w_arb_en && m0_req && m1_req && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end else begin
        r_conflict_cnt <= r_conflict_cnt;
      end
      if (m0_req && !m0_gnt && (r_m0_wait_cnt != 16'hFFFF)) begin
        r_m0_wait_cnt <= r_m0_wait_cnt + 16'd1;
      end else begin
        r_m0_wait_cnt <= r_m0_wait_cnt;
      end
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign m0_wait_cnt  = r_m0_wait_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench. Two arbiter instances are
// exercised: index 0 with RD_LAT=1 and index 1 with RD_LAT=3. The memory
// model returns addr+24 on mem_rdata while MemRead is high.
// Performance counter checks are built when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req   [2];
  logic        m0_we    [2];
  logic [31:0] m0_addr  [2];
  logic [31:0] m0_wdata [2];
  logic        m0_gnt   [2];
  logic        m0_rvalid[2];
  logic [31:0] m0_rdata [2];
  logic        m1_req   [2];
  logic        m1_we    [2];
  logic [31:0] m1_addr  [2];
  logic [31:0] m1_wdata [2];
  logic        m1_gnt   [2];
  logic        m1_rvalid[2];
  logic [31:0] m1_rdata [2];
  logic        MemRead  [2];
  logic        MemWrite [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] conflict_cnt[2];
  logic [15:0] m0_wait_cnt [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  assign mem_rdata[0] = MemRead[0] ? (mem_addr[0] + 32'd24) : 32'd0;
  assign mem_rdata[1] = MemRead[1] ? (mem_addr[1] + 32'd24) : 32'd0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
    .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
    .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
    .MemRead(MemRead[0]), .MemWrite(MemWrite[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
`ifdef DMEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt[0]), .m0_wait_cnt(m0_wait_cnt[0])
`endif
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
    .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
    .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
    .MemRead(MemRead[1]), .MemWrite(MemWrite[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
`ifdef DMEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt[1]), .m0_wait_cnt(m0_wait_cnt[1])
`endif
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: sequence did not complete (n_tests=%0d)", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Move to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge (sample point).
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      m0_req[d] = 1'b0; m0_we[d] = 1'b0; m0_addr[d] = 32'd0; m0_wdata[d] = 32'd0;
      m1_req[d] = 1'b0; m1_we[d] = 1'b0; m1_addr[d] = 32'd0; m1_wdata[d] = 32'd0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq [4];
    int n_g;
    int rv_seen;
    logic [31:0] winner;

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    // Reset state on both instances.
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_memread",  {31'd0, MemRead[d]},  32'd0);
      check_eq("rst_memwrite", {31'd0, MemWrite[d]}, 32'd0);
      check_eq("rst_mem_addr", mem_addr[d],          32'd0);
      check_eq("rst_m0_rdata", m0_rdata[d],          32'd0);
      check_eq("rst_rvalid",   {30'd0, m0_rvalid[d], m1_rvalid[d]}, 32'd0);
    end
`ifdef DMEM_ARB_PERF_EN
    check_eq("rst_conflict_cnt", {16'd0, conflict_cnt[0]}, 32'd0);
    check_eq("rst_m0_wait_cnt",  {16'd0, m0_wait_cnt[0]},  32'd0);
`endif
    cyc();
    rst_n = 1'b1;

    // ---- Single write on port 0 (RD_LAT=1 instance) ----
    cyc();
    m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 32'd5; m0_wdata[0] = 32'd28;
    smp();
    check_eq("wr_gnt",       {31'd0, m0_gnt[0]},   32'd1);
    check_eq("wr_mw_early",  {31'd0, MemWrite[0]}, 32'd0);
    cyc();
    m0_req[0] = 1'b0; m0_we[0] = 1'b0;
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'd7;
    smp();
    check_eq("wr_memwrite",  {31'd0, MemWrite[0]}, 32'd1);
    check_eq("wr_memread",   {31'd0, MemRead[0]},  32'd0);
    check_eq("wr_mem_addr",  mem_addr[0],          32'd5);
    check_eq("wr_mem_wdata", mem_wdata[0],         32'd28);
    check_eq("wr_no_gnt_in_write", {31'd0, m1_gnt[0]}, 32'd0);
    cyc();
    smp();
    check_eq("wr_done_mw",   {31'd0, MemWrite[0]}, 32'd0);
    check_eq("wr_done_addr", mem_addr[0],          32'd0);
    check_eq("wr_done_wd",   mem_wdata[0],         32'd0);
    check_eq("idle_gnt_m1",  {31'd0, m1_gnt[0]},   32'd1);
    cyc();
    m1_req[0] = 1'b0;
    smp();
    check_eq("rd7_memread",  {31'd0, MemRead[0]},  32'd1);
    check_eq("rd7_addr",     mem_addr[0],          32'd7);
    cyc();
    smp();
    check_eq("rd7_rvalid",   {31'd0, m1_rvalid[0]}, 32'd1);
    check_eq("rd7_rdata",    m1_rdata[0],           32'd31);
    cyc();

    // ---- Single read on port 1, addr 18 -> 42 ----
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'd18;
    smp();
    check_eq("rd_gnt_m1",    {31'd0, m1_gnt[0]},   32'd1);
    check_eq("rd_gnt_m0",    {31'd0, m0_gnt[0]},   32'd0);
    cyc();
    m1_req[0] = 1'b0;
    smp();
    check_eq("rd_memread",   {31'd0, MemRead[0]},  32'd1);
    check_eq("rd_mem_addr",  mem_addr[0],          32'd18);
    check_eq("rd_rvalid_early", {31'd0, m1_rvalid[0]}, 32'd0);
    cyc();
    smp();
    check_eq("rd_rvalid",    {31'd0, m1_rvalid[0]}, 32'd1);
    check_eq("rd_rdata",     m1_rdata[0],           32'd42);
    check_eq("rd_m0_rvalid", {31'd0, m0_rvalid[0]}, 32'd0);
    check_eq("rd_mr_off",    {31'd0, MemRead[0]},   32'd0);
    cyc();
    smp();
    check_eq("rd_rvalid_pulse", {31'd0, m1_rvalid[0]}, 32'd0);
    check_eq("rd_rdata_hold",   m1_rdata[0],           32'd42);

    // ---- Conflict after reset: grants alternate 0,1,0,1 ----
    do_reset();
    m0_req[0] = 1'b1; m0_addr[0] = 32'd1;
    m1_req[0] = 1'b1; m1_addr[0] = 32'd2;
    exp_seq = '{0, 1, 0, 1};
    n_g = 0;
    for (int c = 0; c < 20 && n_g < 4; c++) begin
      smp();
      if (m0_gnt[0] || m1_gnt[0]) begin
        check_eq("cf_onehot", {30'd0, m1_gnt[0], m0_gnt[0]}, m1_gnt[0] ? 32'd2 : 32'd1);
        winner = {31'd0, m1_gnt[0]};
        check_eq("cf_winner", winner, exp_seq[n_g]);
        if (n_g == 1) begin
          check_eq("cf_gnt_with_rvalid", {31'd0, m0_rvalid[0]}, 32'd1);
          check_eq("cf_rdata0",          m0_rdata[0],           32'd25);
        end
        n_g++;
      end
      cyc();
    end
    check_eq("cf_grant_count", n_g, 32'd4);
    clear_inputs();
    repeat (4) cyc();

    // ---- Back-to-back reads, RD_LAT=3, port 0 addrs 4 then 8 ----
    m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 32'd4;
    smp();
    check_eq("b2b_gnt1", {31'd0, m0_gnt[1]}, 32'd1);
    cyc();
    m0_addr[1] = 32'd8;
    for (int k = 0; k < 3; k++) begin
      smp();
      check_eq("b2b_mr1",     {31'd0, MemRead[1]},   32'd1);
      check_eq("b2b_addr1",   mem_addr[1],           32'd4);
      check_eq("b2b_nognt1",  {31'd0, m0_gnt[1]},    32'd0);
      check_eq("b2b_norv1",   {31'd0, m0_rvalid[1]}, 32'd0);
      cyc();
    end
    smp();
    check_eq("b2b_rvalid1", {31'd0, m0_rvalid[1]}, 32'd1);
    check_eq("b2b_rdata1",  m0_rdata[1],           32'd28);
    check_eq("b2b_gnt2",    {31'd0, m0_gnt[1]},    32'd1);
    check_eq("b2b_mr_gap",  {31'd0, MemRead[1]},   32'd0);
    cyc();
    m0_req[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      check_eq("b2b_mr2",   {31'd0, MemRead[1]},   32'd1);
      check_eq("b2b_addr2", mem_addr[1],           32'd8);
      check_eq("b2b_norv2", {31'd0, m0_rvalid[1]}, 32'd0);
      cyc();
    end
    smp();
    check_eq("b2b_rvalid2", {31'd0, m0_rvalid[1]}, 32'd1);
    check_eq("b2b_rdata2",  m0_rdata[1],           32'd32);
    cyc();

    // ---- Reset during second READ cycle, RD_LAT=3 ----
    m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 32'd10;
    smp();
    check_eq("rstmid_gnt", {31'd0, m0_gnt[1]}, 32'd1);
    cyc();
    m0_req[1] = 1'b0;
    smp();
    check_eq("rstmid_mr_before", {31'd0, MemRead[1]}, 32'd1);
    cyc();
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_mr_async", {31'd0, MemRead[1]}, 32'd0);
    cyc();
    rst_n = 1'b1;
    rv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      smp();
      if (m0_rvalid[1] || MemRead[1]) rv_seen++;
      cyc();
    end
    check_eq("rstmid_no_rvalid", rv_seen, 32'd0);
    m0_req[1] = 1'b1; m0_addr[1] = 32'd3;
    m1_req[1] = 1'b1; m1_addr[1] = 32'd6;
    smp();
    check_eq("rstmid_cf_m0", {31'd0, m0_gnt[1]}, 32'd1);
    check_eq("rstmid_cf_m1", {31'd0, m1_gnt[1]}, 32'd0);
    cyc();
    clear_inputs();
    repeat (10) cyc();

    // ---- Starvation-free alternation 1,0,1,0 and perf counters ----
    do_reset();
    m1_req[0] = 1'b1; m1_addr[0] = 32'd2;
    smp();
    check_eq("alt_first_m1", {31'd0, m1_gnt[0]}, 32'd1);
    cyc();
    m0_req[0] = 1'b1; m0_addr[0] = 32'd1;
    exp_seq = '{0, 1, 0, 0};
    n_g = 0;
    for (int c = 0; c < 20 && n_g < 3; c++) begin
      smp();
      if (m0_gnt[0] || m1_gnt[0]) begin
        winner = {31'd0, m1_gnt[0]};
        check_eq("alt_winner", winner, exp_seq[n_g]);
        n_g++;
      end
      cyc();
    end
    check_eq("alt_grant_count", n_g, 32'd3);
    clear_inputs();
    repeat (4) cyc();
`ifdef DMEM_ARB_PERF_EN
    smp();
    check_eq("perf_conflict_cnt", {16'd0, conflict_cnt[0]}, 32'd3);
    check_eq("perf_m0_wait_cnt",  {16'd0, m0_wait_cnt[0]},  32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
